spwm_carrier_gen: RTL and testbench

Address sequencer and consumer for the 64×10 triangle-carrier pROM in the SPWM path. It steps the ROM through one 50-entry triangle period at a programmable rate and registers the returned carrier sample. The sample is compared against a shadow-latched modulation value, and the block drives a complementary, dead-time-protected PWM pair to the gate stage.

---
 rtl/spwm_pkg.sv | 27 ++
 rtl/spwm_deadband.sv | 69 ++++++
 rtl/spwm_carrier_gen.sv | 120 ++++++++++++
 tb/tb_spwm_carrier_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spwm_pkg.sv
// Shared constants and types for the SPWM triangle-carrier path.
package spwm_pkg;
  localparam int PEAK_IDX = 25;
  localparam int TBL_LEN  = 2 * PEAK_IDX;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 10;
  localparam int DIV_W    = 16;
  localparam int DT_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DEAD = 2'd3
  } db_state_t;

  // Table index successor; the last valid entry wraps back to the trough.
  function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] idx);
    logic [ADDR_W-1:0] nxt;
    if (idx >= ADDR_W'(TBL_LEN - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + ADDR_W'(1);
    end
    return nxt;
  endfunction
endpackage

// File: rtl/spwm_deadband.sv
// Complementary gate driver: turns the raw compare result into a dead-time-protected PWM pair.
module spwm_deadband
  import spwm_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            raw,
  input  logic            raw_vld,
  input  logic [DT_W-1:0] dead_time,
  output logic            pwm_h,
  output logic            pwm_l
);
  db_state_t       state_q;
  logic [DT_W-1:0] cnt_q;
  logic            target_q;
  logic            pwm_h_q;
  logic            pwm_l_q;
  logic            chg;
  logic            direct;

  assign direct = (dead_time == '0);

  // Detects a request for a new side (first valid compare, or compare disagreeing with the current/target side).
  always_comb begin
    chg = 1'b0;
    case (state_q)
      IDLE:    chg = raw_vld;
      HI:      chg = ~raw;
      LO:      chg = raw;
      DEAD:    chg = (raw != target_q);
      default: chg = 1'b0;
    endcase
  end

  // Deadband state machine with registered gate outputs.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= 1'b0;
      pwm_h_q  <= 1'b0;
      pwm_l_q  <= 1'b0;
    end else if (chg) begin
      target_q <= raw;
      cnt_q    <= dead_time;
      if (direct) begin
        state_q <= raw ? HI : LO;
        pwm_h_q <= raw;
        pwm_l_q <= ~raw;
      end else begin
        state_q <= DEAD;
        pwm_h_q <= 1'b0;
        pwm_l_q <= 1'b0;
      end
    end else if (state_q == DEAD) begin
      if (cnt_q <= DT_W'(1)) begin
        state_q <= target_q ? HI : LO;
        pwm_h_q <= target_q;
        pwm_l_q <= ~target_q;
      end else begin
        cnt_q <= cnt_q - DT_W'(1);
      end
    end
  end

  assign pwm_h = pwm_h_q;
  assign pwm_l = pwm_l_q;
endmodule

// File: rtl/spwm_carrier_gen.sv
// Triangle-carrier ROM sequencer: prescaled address stepping, carrier capture,
// trough-latched modulation shadow and compare feeding the deadband gate driver.
module spwm_carrier_gen
  import spwm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  step_div,
  input  logic [DATA_W-1:0] mod_val,
  input  logic [DT_W-1:0]   dead_time,
  output logic [ADDR_W-1:0] rom_ad,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] carrier,
  output logic              carrier_vld,
  output logic              period_start,
  output logic              pwm_h,
  output logic              pwm_l
);
  logic              run;
  logic              tick;
  logic              rd_vld;
  logic [DIV_W-1:0]  presc_q;
  logic [DIV_W-1:0]  presc_d;
  logic [ADDR_W-1:0] ad_q;
  logic [ADDR_W-1:0] ad_d;
  logic              ad_new_q;
  logic              primed_q;
  logic              b_vld_q;
  logic [ADDR_W-1:0] b_idx_q;
  logic [DATA_W-1:0] carrier_q;
  logic              carrier_vld_q;
  logic              period_start_q;
  logic [DATA_W-1:0] mod_q;
  logic [DATA_W-1:0] mod_eff;
  logic              raw_q;
  logic              raw_vld_q;

  assign run = en & rst_n;
  // >= keeps the prescaler from running away if step_div is lowered below the current count.
  assign tick   = (presc_q >= step_div);
  assign rd_vld = ad_new_q | ~primed_q;
  // The trough capture compares against the value being latched into the shadow in that same cycle.
  assign mod_eff = (b_idx_q == '0) ? mod_val : mod_q;

  // Prescaler and table-address next state.
  always_comb begin
    if (tick) begin
      presc_d = '0;
      ad_d    = next_idx(ad_q);
    end else begin
      presc_d = presc_q + DIV_W'(1);
      ad_d    = ad_q;
    end
  end

  // Prescaler, ROM address and the valid/index flags travelling with each read.
  always_ff @(posedge clk) begin
    if (!run) begin
      presc_q  <= '0;
      ad_q     <= '0;
      ad_new_q <= 1'b0;
      primed_q <= 1'b0;
      b_vld_q  <= 1'b0;
      b_idx_q  <= '0;
    end else begin
      presc_q  <= presc_d;
      ad_q     <= ad_d;
      ad_new_q <= tick;
      primed_q <= 1'b1;
      b_vld_q  <= rd_vld;
      b_idx_q  <= ad_q;
    end
  end

  // Carrier capture, modulation shadow and unsigned compare.
  always_ff @(posedge clk) begin
    if (!run) begin
      carrier_q      <= '0;
      carrier_vld_q  <= 1'b0;
      period_start_q <= 1'b0;
      mod_q          <= '0;
      raw_q          <= 1'b0;
      raw_vld_q      <= 1'b0;
    end else begin
      carrier_vld_q  <= b_vld_q;
      period_start_q <= b_vld_q & (b_idx_q == '0);
      raw_vld_q      <= b_vld_q;
      if (b_vld_q) begin
        carrier_q <= rom_dout;
        raw_q     <= (mod_eff > rom_dout);
        if (b_idx_q == '0) begin
          mod_q <= mod_val;
        end
      end
    end
  end

  spwm_deadband u_deadband (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .raw       (raw_q),
    .raw_vld   (raw_vld_q),
    .dead_time (dead_time),
    .pwm_h     (pwm_h),
    .pwm_l     (pwm_l)
  );

  assign rom_ad       = ad_q;
  assign rom_ce       = run;
  assign rom_oce      = 1'b1;
  assign rom_reset    = ~rst_n;
  assign carrier      = carrier_q;
  assign carrier_vld  = carrier_vld_q;
  assign period_start = period_start_q;
endmodule

// File: tb/tb_spwm_carrier_gen.sv
// Self-checking bench for spwm_carrier_gen: bench-owned triangle ROM and a time-indexed reference model.
`timescale 1ns/1ps
module tb_spwm_carrier_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] step_div = 16'd0;
  logic [9:0]  mod_val = 10'd0;
  logic [7:0]  dead_time = 8'd0;
  logic [5:0]  rom_ad;
  logic        rom_ce, rom_oce, rom_reset;
  logic [9:0]  rom_dout = 10'd0;
  logic [9:0]  carrier;
  logic        carrier_vld, period_start, pwm_h, pwm_l;

  int vectors = 0;
  int miscompares = 0;
  int tbl [0:63];
  // Reference model state: t = clock edges since the run was enabled.
  int t = 0, r_t = 0, shadow = 0, mod_edge = 0;
  int exp_carrier = 0, exp_ad = 0, exp_idx = -1;
  bit have_r = 1'b0, raw_m = 1'b0;
  bit exp_vld = 1'b0, exp_ps = 1'b0, exp_h = 1'b0, exp_l = 1'b0;

  spwm_carrier_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .step_div(step_div), .mod_val(mod_val),
    .dead_time(dead_time), .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce),
    .rom_reset(rom_reset), .rom_dout(rom_dout), .carrier(carrier),
    .carrier_vld(carrier_vld), .period_start(period_start), .pwm_h(pwm_h), .pwm_l(pwm_l)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_ce) rom_dout <= 10'(tbl[rom_ad]);

  // Advance one clock and compute what the outputs should be in the new cycle.
  task automatic cycle();
    int sd1;
    bit r_new;
    @(posedge clk);
    mod_edge = int'(mod_val);
    if (en && rst_n) t = t + 1; else t = 0;
    @(negedge clk);
    sd1 = int'(step_div) + 1;
    if (t == 0) begin
      exp_carrier = 0; exp_ad = 0; exp_vld = 0; exp_ps = 0; exp_h = 0; exp_l = 0;
      shadow = 0; have_r = 0; raw_m = 0; exp_idx = -1;
    end else begin
      exp_ad = (t / sd1) % 50;
      exp_vld = (t >= 2) && ((t - 2) % sd1 == 0);
      exp_ps = 1'b0;
      // Gates follow the compare one clock late, blanked for dead_time clocks after each change.
      if (!have_r) begin exp_h = 0; exp_l = 0; end
      else if (t - r_t <= int'(dead_time)) begin exp_h = 0; exp_l = 0; end
      else begin exp_h = raw_m; exp_l = !raw_m; end
      if (exp_vld) begin
        exp_idx = ((t - 2) / sd1) % 50;
        exp_carrier = tbl[exp_idx];
        if (exp_idx == 0) begin shadow = mod_edge; exp_ps = 1'b1; end
        r_new = (shadow > exp_carrier);
        if (!have_r || r_new != raw_m) begin r_t = t; have_r = 1'b1; end
        raw_m = r_new;
      end
    end
  endtask

  task automatic start_run(input int sd, input int dt, input int mv);
    en = 1'b0; rst_n = 1'b1;
    cycle();
    step_div = 16'(sd); dead_time = 8'(dt); mod_val = 10'(mv); en = 1'b1;
  endtask

  function automatic int pick_mod();
    case ($urandom_range(2))
      0: return 1000 + int'($urandom_range(22));
      1: return 42 + int'($urandom_range(39));
      default: return int'($urandom_range(1023));
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mod_val = 10'd300;
    repeat (3) begin
      cycle();
      vectors++;
      if ({carrier, carrier_vld, period_start, pwm_h, pwm_l, rom_ad, rom_ce, rom_reset, rom_oce} !==
          {10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1}) begin
        miscompares++;
        $display("FAIL reset got car=%0d vld=%b ps=%b h=%b l=%b ad=%0d ce=%b rst=%b oce=%b want zeros with rst=1 oce=1",
                 carrier, carrier_vld, period_start, pwm_h, pwm_l, rom_ad, rom_ce, rom_reset, rom_oce);
      end
    end
  endtask

  task automatic test_sequence();
    start_run(0, 0, int'($urandom_range(1023)));
    repeat (130) begin
      cycle();
      vectors++;
      if ({carrier, carrier_vld, period_start, rom_ad, rom_ce} !== {10'(exp_carrier), exp_vld, exp_ps, 6'(exp_ad), 1'b1}) begin
        miscompares++;
        $display("FAIL sequence t=%0d got car=%0d vld=%b ps=%b ad=%0d ce=%b want car=%0d vld=%b ps=%b ad=%0d ce=1",
                 t, carrier, carrier_vld, period_start, rom_ad, rom_ce, exp_carrier, exp_vld, exp_ps, exp_ad);
      end
    end
  endtask

  task automatic test_step_div();
    int last_v = -1;
    start_run(3, 0, int'($urandom_range(1023)));
    repeat (420) begin
      cycle();
      vectors++;
      if ({carrier, carrier_vld, period_start, rom_ad} !== {10'(exp_carrier), exp_vld, exp_ps, 6'(exp_ad)}) begin
        miscompares++;
        $display("FAIL step_div t=%0d got car=%0d vld=%b ps=%b ad=%0d want car=%0d vld=%b ps=%b ad=%0d",
                 t, carrier, carrier_vld, period_start, rom_ad, exp_carrier, exp_vld, exp_ps, exp_ad);
      end
      if (carrier_vld === 1'b1) begin
        if (last_v >= 0) begin
          vectors++;
          if (t - last_v != 4) begin
            miscompares++;
            $display("FAIL vld_spacing t=%0d got %0d want 4", t, t - last_v);
          end
        end
        last_v = t;
      end
    end
  endtask

  task automatic test_compare_nodead();
    int highs = 0;
    start_run(0, 0, 512);
    repeat (110) begin
      cycle();
      vectors++;
      if ({pwm_h, pwm_l} !== {exp_h, exp_l}) begin
        miscompares++;
        $display("FAIL nodead_gates t=%0d got h=%b l=%b want h=%b l=%b", t, pwm_h, pwm_l, exp_h, exp_l);
      end
      if (t >= 3) begin
        vectors++;
        if (pwm_l !== ~pwm_h) begin
          miscompares++;
          $display("FAIL nodead_compl t=%0d got h=%b l=%b want l=~h", t, pwm_h, pwm_l);
        end
      end
      if (t >= 3 && t <= 52 && pwm_h === 1'b1) highs++;
    end
    vectors++;
    if (highs != 25) begin
      miscompares++;
      $display("FAIL raw_high_count got %0d want 25", highs);
    end
  endtask

  task automatic test_deadband();
    for (int run = 0; run < 4; run++) begin
      start_run(int'($urandom_range(2)), (run == 3) ? int'($urandom_range(6)) : 3, pick_mod());
      for (int k = 0; k < 240; k++) begin
        cycle();
        vectors++;
        if ({pwm_h, pwm_l} !== {exp_h, exp_l}) begin
          miscompares++;
          $display("FAIL deadband run=%0d t=%0d dt=%0d got h=%b l=%b want h=%b l=%b",
                   run, t, dead_time, pwm_h, pwm_l, exp_h, exp_l);
        end
        vectors++;
        if ((pwm_h & pwm_l) !== 1'b0) begin
          miscompares++;
          $display("FAIL overlap t=%0d got h=%b l=%b want not both 1", t, pwm_h, pwm_l);
        end
        if (k % 37 == 36) mod_val = 10'(pick_mod());
      end
    end
  endtask

  task automatic test_boundaries();
    int mods [3] = '{0, 1023, 200};
    for (int b = 0; b < 3; b++) begin
      start_run(0, 0, mods[b]);
      for (int k = 0; k < 120; k++) begin
        cycle();
        vectors++;
        if ({pwm_h, pwm_l} !== {exp_h, exp_l}) begin
          miscompares++;
          $display("FAIL boundary mod=%0d t=%0d got h=%b l=%b want h=%b l=%b", mods[b], t, pwm_h, pwm_l, exp_h, exp_l);
        end
        if (b == 0) begin
          vectors++;
          if (pwm_h !== 1'b0) begin
            miscompares++;
            $display("FAIL mod_zero t=%0d got h=%b want 0", t, pwm_h);
          end
        end
        if (b == 2 && k == 20) mod_val = 10'd800;
      end
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 3; run++) begin
      start_run(int'($urandom_range(3)), int'($urandom_range(5)), int'($urandom_range(1023)));
      repeat (300) begin
        cycle();
        vectors++;
        if ({carrier, carrier_vld, period_start, rom_ad, pwm_h, pwm_l} !==
            {10'(exp_carrier), exp_vld, exp_ps, 6'(exp_ad), exp_h, exp_l}) begin
          miscompares++;
          $display("FAIL random t=%0d got car=%0d vld=%b ps=%b ad=%0d h=%b l=%b want car=%0d vld=%b ps=%b ad=%0d h=%b l=%b",
                   t, carrier, carrier_vld, period_start, rom_ad, pwm_h, pwm_l,
                   exp_carrier, exp_vld, exp_ps, exp_ad, exp_h, exp_l);
        end
        mod_val = 10'($urandom_range(1023));
      end
    end
  endtask

  task automatic test_disable();
    for (int mode = 0; mode < 2; mode++) begin
      bit hit = 1'b0;
      start_run(1, 2, int'($urandom_range(1023)));
      for (int k = 0; k < 400 && !hit; k++) begin
        cycle();
        hit = exp_vld && (exp_idx == 30);
      end
      vectors++;
      if (!hit || carrier !== 10'(tbl[30])) begin
        miscompares++;
        $display("FAIL reach_idx30 got car=%0d reached=%b want car=%0d reached=1", carrier, hit, tbl[30]);
      end
      if (mode == 0) en = 1'b0; else rst_n = 1'b0;
      cycle();
      vectors++;
      if ({carrier, carrier_vld, period_start, rom_ad, rom_ce, pwm_h, pwm_l, rom_reset} !==
          {10'(exp_carrier), exp_vld, exp_ps, 6'(exp_ad), 1'b0, exp_h, exp_l, (mode == 1)}) begin
        miscompares++;
        $display("FAIL drop mode=%0d got car=%0d vld=%b ps=%b ad=%0d ce=%b h=%b l=%b rst=%b want zeros rst=%0d",
                 mode, carrier, carrier_vld, period_start, rom_ad, rom_ce, pwm_h, pwm_l, rom_reset, mode);
      end
      en = 1'b1; rst_n = 1'b1;
      repeat (6) begin
        cycle();
        vectors++;
        if ({carrier, carrier_vld, period_start, rom_ad, pwm_h, pwm_l} !==
            {10'(exp_carrier), exp_vld, exp_ps, 6'(exp_ad), exp_h, exp_l}) begin
          miscompares++;
          $display("FAIL restart mode=%0d t=%0d got car=%0d vld=%b ps=%b ad=%0d want car=%0d vld=%b ps=%b ad=%0d",
                   mode, t, carrier, carrier_vld, period_start, rom_ad, exp_carrier, exp_vld, exp_ps, exp_ad);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      tbl[i] = (i <= 25) ? (i * 1023 + 12) / 25 : (i < 50) ? ((50 - i) * 1023 + 12) / 25 : 0;
    test_reset();
    test_sequence();
    test_step_div();
    test_compare_nodead();
    test_deadband();
    test_boundaries();
    test_random();
    test_disable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
